// File: rtl/pulse_to_level_pkg.sv
// Shared types for the pulse-to-level converter: FSM state encoding.
package pulse_to_level_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/pl_down_counter.sv
// Loadable down-counter with terminal-count flag; parks at zero rather than wrapping.
module pl_down_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_to_level_converter.sv
// Stretches a one-cycle trigger into a held level of programmable length,
// followed by an optional forced-low gap before the next window.
//
// state | meaning
// IDLE  | level low, waiting for a trigger
// HOLD  | level high, hold counter running
// GAP   | level low, triggers dropped until gap counter expires
module pulse_to_level_converter
  import pulse_to_level_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_GAP   = 1,
  parameter int RETRIGGER = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pulse,
  input  logic [CNT_W-1:0]   hold_len,
  output logic               level,
  output logic               done,
  output logic               overrun,
  output logic [STATE_W-1:0] statemon
);

  localparam logic [7:0] GAP_LOAD = (MIN_GAP > 0) ? 8'(MIN_GAP - 1) : 8'd0;

  state_t           state;
  state_t           state_nxt;
  logic             hold_load;
  logic             hold_dec;
  logic             hold_zero;
  logic             gap_load;
  logic             gap_dec;
  logic             gap_zero;
  logic             drop;
  logic [CNT_W-1:0] hold_load_val;

  // A zero length behaves as one cycle, so the reload value is max(hold_len,1)-1.
  assign hold_load_val = (hold_len == '0) ? '0 : hold_len - CNT_W'(1);

  pl_down_counter #(.W(CNT_W)) u_hold_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (hold_load),
    .load_val (hold_load_val),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  pl_down_counter #(.W(8)) u_gap_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (pulse) begin
          state_nxt = HOLD;
          hold_load = 1'b1;
        end
      end
      HOLD: begin
        // A retrigger outranks the terminal count, so a pulse on the last cycle extends.
        if (pulse && (RETRIGGER != 0)) begin
          hold_load = 1'b1;
        end else begin
          drop = pulse;
          if (hold_zero) begin
            if (MIN_GAP == 0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = GAP;
              gap_load  = 1'b1;
            end
          end else begin
            hold_dec = 1'b1;
          end
        end
      end
      GAP: begin
        drop = pulse;
        if (gap_zero) begin
          state_nxt = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      level   <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      level   <= (state_nxt == HOLD);
      done    <= (state == HOLD) && (state_nxt != HOLD);
      overrun <= drop;
    end
  end

  assign statemon = state;

endmodule
